counter_b32_arbiter: RTL
========================

Name: counter_b32_arbiter

Overview:
Round-robin scheduler that shares one counter_b32 instance between NREQ requesters. Each requester posts an operation (mode, load value, run length). The arbiter grants one requester at a time and drives b32_enable/b32_mode/b32_D for the requested number of cycles, then pulses done to the winner. It sits between the requester blocks and the counter in the counter_b32 test/design flow.

Parameters:
NREQ, 4, number of requesters (2..8)
DWIDTH, 32, counter data width (b32_D, req_D slices)
LWIDTH, 8, run-length field width per requester

Ports:
b32_clk  input  1  single clock, all logic on rising edge
b32_reset  input  1  synchronous reset, active-high
req  input  NREQ  per-requester request level
req_mode  input  2*NREQ  requested counter mode; slice i = bits [2i+1:2i]
req_D  input  DWIDTH*NREQ  requested load value; slice i
req_len  input  LWIDTH*NREQ  requested enable cycles; slice i
b32_rco  input  1  counter ripple-carry-out (bit 0 of counter rco)
gnt  output  NREQ  one-hot grant, held for the whole operation
done  output  NREQ  one-cycle completion pulse to the granted requester
busy  output  1  high in every state except IDLE
b32_enable  output  1  counter enable
b32_mode  output  2  counter mode
b32_D  output  DWIDTH  counter load value
rco_abort  output  1  one-cycle pulse when a run ends early on rco

Behaviour:
- Clock/reset: one clock, b32_clk; reset b32_reset is synchronous and active-high.
- All outputs are registered. Reset value of every output is 0. Round-robin pointer resets to 0 and the FSM to IDLE.
- FSM states: IDLE, GRANT, RUN, DONE.
- IDLE: if any req bit is high, pick the first set bit at index >= ptr, wrapping modulo NREQ. Next state is GRANT. No request: stay in IDLE.
- GRANT (1 cycle): latch the winner's mode, D and len. gnt[w]=1, b32_mode and b32_D driven, b32_enable=0. Go to RUN.
- RUN: b32_enable=1, with mode and D held stable.
  - cnt loads len; len=0 is treated as 1.
  - Decrement cnt each cycle; on the cycle cnt reaches 1, go to DONE.
  - Mode 2'b11 (load) always runs exactly 1 enable cycle, ignoring len.
- DONE (1 cycle): b32_enable=0, done[w]=1, gnt[w] still 1. ptr <= (w+1) mod NREQ. Next state is IDLE; gnt clears.
- Latency: req high at edge N gives gnt at N+1 and first b32_enable at N+2. done pulses len cycles after the first enable. A back-to-back grant is earliest 1 cycle after DONE, because IDLE is always visited.
- Requester dropping req while granted: ignored; the operation completes and done still pulses.
- Changing req_* slices after GRANT: no effect, since values are latched.
- Simultaneous requests: strict round-robin from ptr; no requester is starved. With all NREQ requesting, each is served once per NREQ operations.
- Reset mid-RUN: at the next edge, outputs return to 0, state to IDLE and ptr to 0. No done pulse is issued.
- b32_mode/b32_D return to 0 in IDLE.

Optional Feature:
COUNTER_B32_RCO_ABORT_EN
- Defined: in RUN, if b32_rco is sampled high, go to DONE on the next edge regardless of cnt. rco_abort pulses in that DONE cycle together with done.
- Not defined: b32_rco is ignored and rco_abort is tied to 0. The port list is identical in both builds.

Test Plan:
1. Single request: reset 5 cycles, then req=4'b0001, mode=2'b00, D=0, len=5 → gnt=0001 at N+1, b32_enable high for exactly 5 cycles, done=0001 one cycle, busy low after.
2. Load op: req[2] with mode=2'b11, D=32'h0000_00AB, len=20 → exactly 1 enable cycle with b32_mode=11 and b32_D=AB, then done[2].
3. Round-robin: req=4'b1111 held, len=2 each → grant order 0,1,2,3,0 with no repeats; ptr wraps correctly.
4. len=0 and req drop: req[1] len=0 gives 1 enable cycle. Separately, drop req[1] during RUN → operation completes and done[1] still pulses.
5. Reset mid-RUN: assert b32_reset in the 3rd RUN cycle of a len=10 op → next edge all outputs 0, no done pulse; a following request from index 3 is granted from ptr=0.
6. With COUNTER_B32_RCO_ABORT_EN: len=50, force b32_rco=1 at the 4th enable cycle → DONE next cycle, done and rco_abort pulse together. Without the macro, the same stimulus gives the full 50 enable cycles and rco_abort=0.

Source files
------------

// File: rtl/counter_b32_arbiter.sv
// Round-robin scheduler sharing one counter_b32 between NREQ requesters.
// Optional macro COUNTER_B32_RCO_ABORT_EN ends a run early when b32_rco is seen high.
module counter_b32_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32,
    parameter int LWIDTH = 8
) (
    input  logic                     b32_clk,
    input  logic                     b32_reset,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        req_mode,
    input  logic [DWIDTH*NREQ-1:0]   req_D,
    input  logic [LWIDTH*NREQ-1:0]   req_len,
    input  logic                     b32_rco,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic                     b32_enable,
    output logic [1:0]               b32_mode,
    output logic [DWIDTH-1:0]        b32_D,
    output logic                     rco_abort
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Handshake: a requester holds req high until it sees done; req is only
    // looked at in IDLE, so dropping it while granted has no effect.
    state_t              state, state_next;
    logic [PW-1:0]       ptr, ptr_next;
    logic [PW-1:0]       win, win_next;
    logic [LWIDTH-1:0]   cnt, cnt_next;
    logic [NREQ-1:0]     gnt_next, done_next;
    logic                busy_next, enable_next, abort_next;
    logic [1:0]          mode_next;
    logic [DWIDTH-1:0]   d_next;
    logic                found;
    logic [PW-1:0]       pick, cand;
    logic                rco_hit;

    logic [1:0]          mode_arr [NREQ];
    logic [DWIDTH-1:0]   d_arr    [NREQ];
    logic [LWIDTH-1:0]   len_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign mode_arr[g] = req_mode[2*g +: 2];
        assign d_arr[g]    = req_D[DWIDTH*g +: DWIDTH];
        assign len_arr[g]  = req_len[LWIDTH*g +: LWIDTH];
    end

`ifdef COUNTER_B32_RCO_ABORT_EN
    assign rco_hit = b32_rco;
`else
    logic unused_rco;
    assign unused_rco = b32_rco;
    assign rco_hit    = 1'b0;
`endif

    // A load op always takes one enable cycle; a zero length counts as one.
    function automatic logic [LWIDTH-1:0] eff_len(input logic [1:0] m,
                                                  input logic [LWIDTH-1:0] l);
        if (m == 2'b11 || l == '0) return LWIDTH'(1);
        return l;
    endfunction

    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        win_next    = win;
        cnt_next    = cnt;
        mode_next   = b32_mode;
        d_next      = b32_D;
        abort_next  = 1'b0;
        found       = 1'b0;
        pick        = ptr;
        cand        = ptr;

        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        unique case (state)
            IDLE: begin
                mode_next = '0;
                d_next    = '0;
                if (found) begin
                    state_next = GRANT;
                    win_next   = pick;
                    mode_next  = mode_arr[pick];
                    d_next     = d_arr[pick];
                    cnt_next   = eff_len(mode_arr[pick], len_arr[pick]);
                end
            end
            GRANT: state_next = RUN;
            RUN: begin
                if (cnt == LWIDTH'(1) || rco_hit) begin
                    state_next = DONE;
                    abort_next = rco_hit && (cnt != LWIDTH'(1));
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                ptr_next   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                mode_next  = '0;
                d_next     = '0;
            end
            default: state_next = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        gnt_next    = (state_next != IDLE) ? (NREQ'(1) << win_next) : '0;
        done_next   = (state_next == DONE) ? (NREQ'(1) << win_next) : '0;
        busy_next   = (state_next != IDLE);
        enable_next = (state_next == RUN);
    end

    always_ff @(posedge b32_clk) begin
        if (b32_reset) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            cnt        <= '0;
            gnt        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            b32_enable <= 1'b0;
            b32_mode   <= '0;
            b32_D      <= '0;
            rco_abort  <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            win        <= win_next;
            cnt        <= cnt_next;
            gnt        <= gnt_next;
            done       <= done_next;
            busy       <= busy_next;
            b32_enable <= enable_next;
            b32_mode   <= mode_next;
            b32_D      <= d_next;
            rco_abort  <= abort_next;
        end
    end

endmodule
